hba_arbiter: RTL and testbench

Round-robin arbiter that shares the HBA bus between up to 8 bus masters, e.g. a UART command master and a GPIO-interrupt service master.
- Each master raises a request and drives the bus only while its grant bit is high. Non-granted masters drive zeros, and the bus is the OR of all master outputs.
- The arbiter watches hba_select/hba_xferack so it never revokes a grant mid-transfer.
- It sits between the masters and the slave peripherals on the HBA bus.

---
 rtl/hba_arbiter.sv | 156 +++++++++++++++
 tb/tb_hba_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hba_arbiter.sv
// hba_arbiter: round-robin arbiter for up to 8 HBA bus masters.
// The grant is held for the whole transfer and released only when the owner
// drops its request and no transfer is in flight (or the transfer is acked).
// Optional watchdog: define HBA_ARB_TIMEOUT_EN to enable a grant timeout
// that revokes a stuck owner and masks its request until it drops.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no grant; arbitrate among unmasked requests each cycle
// GRANT   | one master owns the bus; hold until request drop / xferack
// RELEASE | single dead cycle with no grant before the next arbitration
module hba_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int OWNER_W        = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   hba_clk,
    input  logic                   hba_reset,
    input  logic [NUM_MASTERS-1:0] hba_mreq,
    input  logic                   hba_select,
    input  logic                   hba_xferack,
    output logic [NUM_MASTERS-1:0] hba_mgrant,
    output logic                   arb_busy,
    output logic [OWNER_W-1:0]     arb_owner,
    output logic                   arb_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [OWNER_W-1:0]     owner_q, owner_d;

    logic [NUM_MASTERS-1:0] req_mask;
    logic [NUM_MASTERS-1:0] req_eff;
    logic                   scan_found;
    logic [OWNER_W-1:0]     scan_winner;
    logic [NUM_MASTERS-1:0] scan_onehot;
    logic                   owner_req;
    logic                   release_ok;

`ifdef HBA_ARB_TIMEOUT_EN
    logic [NUM_MASTERS-1:0] mask_q, mask_d;
    logic [15:0]            wdog_q, wdog_d;
    logic                   timeout_q, timeout_d;

    assign req_mask    = mask_q;
    assign arb_timeout = timeout_q;
`else
    assign req_mask    = '0;
    assign arb_timeout = 1'b0;
`endif

    assign req_eff    = hba_mreq & ~req_mask;
    // grant_q is one-hot on the owner while in GRANT, so this is mreq[owner]
    assign owner_req  = |(hba_mreq & grant_q);
    assign release_ok = !owner_req && (!hba_select || hba_xferack);

    assign hba_mgrant = grant_q;
    assign arb_busy   = |grant_q;
    assign arb_owner  = owner_q;

    // Rotating priority scan starting one past the last owner.
    always_comb begin
        scan_found  = 1'b0;
        scan_winner = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!scan_found && req_eff[(int'(owner_q) + i) % NUM_MASTERS]) begin
                scan_found  = 1'b1;
                scan_winner = OWNER_W'((int'(owner_q) + i) % NUM_MASTERS);
            end
        end
        scan_onehot = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            scan_onehot[j] = (OWNER_W'(j) == scan_winner);
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
`ifdef HBA_ARB_TIMEOUT_EN
        mask_d    = mask_q & hba_mreq;
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (scan_found) begin
                    grant_d = scan_onehot;
                    owner_d = scan_winner;
                    state_d = GRANT;
`ifdef HBA_ARB_TIMEOUT_EN
                    wdog_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (release_ok) begin
                    grant_d = '0;
                    state_d = RELEASE;
                end
`ifdef HBA_ARB_TIMEOUT_EN
                else if (hba_xferack) begin
                    wdog_d = '0;
                end else if (wdog_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    // revoke even mid-transfer; park the owner behind its mask
                    grant_d   = '0;
                    state_d   = RELEASE;
                    timeout_d = 1'b1;
                    mask_d    = (mask_q & hba_mreq) | grant_q;
                end else begin
                    wdog_d = wdog_q + 16'd1;
                end
`endif
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge hba_clk) begin
        if (!hba_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= OWNER_W'(NUM_MASTERS - 1);
`ifdef HBA_ARB_TIMEOUT_EN
            mask_q    <= '0;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
`ifdef HBA_ARB_TIMEOUT_EN
            mask_q    <= mask_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
`endif
        end
    end

endmodule

// File: tb/tb_hba_arbiter.sv
// Directed bench for hba_arbiter (default 4 masters); the watchdog section
// is active when HBA_ARB_TIMEOUT_EN is defined.
module tb_hba_arbiter;

    logic       hba_clk;
    logic       hba_reset;
    logic [3:0] hba_mreq;
    logic       hba_select;
    logic       hba_xferack;
    logic [3:0] hba_mgrant;
    logic       arb_busy;
    logic [2:0] arb_owner;
    logic       arb_timeout;

    int n_tests = 0;
    int n_fail  = 0;
    int order [5];

    hba_arbiter #(
        .NUM_MASTERS   (4),
        .OWNER_W       (3),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .hba_clk    (hba_clk),
        .hba_reset  (hba_reset),
        .hba_mreq   (hba_mreq),
        .hba_select (hba_select),
        .hba_xferack(hba_xferack),
        .hba_mgrant (hba_mgrant),
        .arb_busy   (arb_busy),
        .arb_owner  (arb_owner),
        .arb_timeout(arb_timeout)
    );

    initial hba_clk = 1'b0;
    always #5 hba_clk = ~hba_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // advance one edge and sample 1 ns later; grant invariants checked every cycle
    task automatic tick();
        @(posedge hba_clk);
        #1;
        check("onehot0", 32'($onehot0(hba_mgrant)), 32'd1);
        check("busy_eq_grant", 32'(arb_busy), 32'(|hba_mgrant));
    endtask

    task automatic wait_grant();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!got) begin
                tick();
                if (hba_mgrant != 4'b0000) got = 1'b1;
            end
        end
        check("wait_grant", 32'(got), 32'd1);
    endtask

    task automatic do_reset();
        hba_reset   = 1'b0;
        hba_mreq    = 4'b0000;
        hba_select  = 1'b0;
        hba_xferack = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        hba_reset = 1'b1;
    endtask

    initial begin
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;

        // reset state
        do_reset();
        check("rst_grant", 32'(hba_mgrant), 32'h0);
        check("rst_busy", 32'(arb_busy), 32'h0);
        check("rst_owner", 32'(arb_owner), 32'd3);
        check("rst_timeout", 32'(arb_timeout), 32'h0);

        // two requesters: 0 wins first, then 2 after release + dead cycle
        hba_mreq = 4'b0101;
        tick();
        check("t1_grant0", 32'(hba_mgrant), 32'b0001);
        check("t1_owner0", 32'(arb_owner), 32'd0);
        tick();
        check("t1_hold0", 32'(hba_mgrant), 32'b0001);
        hba_mreq = 4'b0100;
        tick();
        check("t1_rel", 32'(hba_mgrant), 32'h0);
        tick();
        check("t1_dead", 32'(hba_mgrant), 32'h0);
        tick();
        check("t1_grant2", 32'(hba_mgrant), 32'b0100);
        check("t1_owner2", 32'(arb_owner), 32'd2);
        hba_mreq = 4'b0000;
        tick();
        tick();
        tick();
        check("t1_idle_grant", 32'(hba_mgrant), 32'h0);
        check("t1_owner_kept", 32'(arb_owner), 32'd2);

        // all four requesting: rotation 0,1,2,3,0
        do_reset();
        hba_mreq = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("rr_grant", 32'(hba_mgrant), 32'd1 << order[k]);
            check("rr_owner", 32'(arb_owner), 32'(order[k]));
            for (int h = 0; h < 3; h++) begin
                tick();
                check("rr_hold", 32'(hba_mgrant), 32'd1 << order[k]);
            end
            hba_mreq[order[k]] = 1'b0;
            tick();
            check("rr_release", 32'(hba_mgrant), 32'h0);
            hba_mreq[order[k]] = 1'b1;
            tick();
            check("rr_dead", 32'(hba_mgrant), 32'h0);
        end
        hba_mreq = 4'b0000;

        // master 1 drops request mid-transfer; grant waits for xferack
        hba_mreq = 4'b0010;
        wait_grant();
        check("t3_grant1", 32'(hba_mgrant), 32'b0010);
        hba_select = 1'b1;
        hba_mreq   = 4'b0000;
        for (int h = 0; h < 4; h++) begin
            tick();
            check("t3_hold_inflight", 32'(hba_mgrant), 32'b0010);
        end
        hba_xferack = 1'b1;
        tick();
        check("t3_rel_on_ack", 32'(hba_mgrant), 32'h0);
        hba_xferack = 1'b0;
        hba_select  = 1'b0;
        tick();
        check("t3_dead", 32'(hba_mgrant), 32'h0);
        tick();

        // reset while master 2 owns the bus mid-transfer
        hba_mreq = 4'b0100;
        wait_grant();
        check("t4_grant2", 32'(hba_mgrant), 32'b0100);
        hba_select = 1'b1;
        tick();
        check("t4_hold", 32'(hba_mgrant), 32'b0100);
        hba_reset = 1'b0;
        tick();
        check("t4_rst_grant", 32'(hba_mgrant), 32'h0);
        check("t4_rst_owner", 32'(arb_owner), 32'd3);
        check("t4_rst_busy", 32'(arb_busy), 32'h0);
        hba_reset  = 1'b1;
        hba_select = 1'b0;
        hba_mreq   = 4'b0101;
        tick();
        check("t4_after_rst", 32'(hba_mgrant), 32'b0001);
        check("t4_after_owner", 32'(arb_owner), 32'd0);
        hba_mreq = 4'b0000;
        tick();
        tick();

        // single master re-requesting right after release
        hba_mreq = 4'b0001;
        tick();
        check("t6_grant", 32'(hba_mgrant), 32'b0001);
        for (int h = 0; h < 2; h++) begin
            tick();
            check("t6_hold", 32'(hba_mgrant), 32'b0001);
        end
        hba_mreq = 4'b0000;
        tick();
        check("t6_gap1", 32'(hba_mgrant), 32'h0);
        hba_mreq = 4'b0001;
        tick();
        check("t6_gap2", 32'(hba_mgrant), 32'h0);
        tick();
        check("t6_regrant", 32'(hba_mgrant), 32'b0001);
        hba_mreq = 4'b0000;
        tick();
        tick();

`ifdef HBA_ARB_TIMEOUT_EN
        // master 3 stuck: revoke 8 cycles after grant, then masked
        do_reset();
        hba_mreq = 4'b1000;
        tick();
        check("to_grant3", 32'(hba_mgrant), 32'b1000);
        hba_mreq = 4'b1001;
        for (int h = 0; h < 7; h++) begin
            tick();
            check("to_hold", 32'(hba_mgrant), 32'b1000);
            check("to_no_pulse", 32'(arb_timeout), 32'h0);
        end
        tick();
        check("to_revoke", 32'(hba_mgrant), 32'h0);
        check("to_pulse", 32'(arb_timeout), 32'h1);
        tick();
        check("to_pulse_end", 32'(arb_timeout), 32'h0);
        tick();
        check("to_grant0", 32'(hba_mgrant), 32'b0001);
        hba_mreq = 4'b1000;
        for (int h = 0; h < 4; h++) tick();
        check("to_masked", 32'(hba_mgrant), 32'h0);
        hba_mreq = 4'b0000;
        tick();
        hba_mreq = 4'b1000;
        tick();
        check("to_unmasked", 32'(hba_mgrant), 32'b1000);
        hba_mreq = 4'b0000;
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
